// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_pkg
//  Purpose  : Shared state encoding, flag bit positions and flag-byte helper
//             for the sequential restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    // Controller states; encodings match the rest of the ALU control logic
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flag byte bit positions, common to every ALU unit
    localparam int c_ZF_BIT = 0;
    localparam int c_CF_BIT = 1;
    localparam int c_OF_BIT = 2;
    localparam int c_NF_BIT = 3;

    // Assemble the flags byte {4'b0, NF, OF, CF, ZF} from its conditions
    function automatic logic [7:0] make_flags(
        input logic is_zero,
        input logic is_neg,
        input logic is_wide,
        input logic div_zero
    );
        logic [7:0] v_flags;
        v_flags           = 8'h00;
        v_flags[c_ZF_BIT] = is_zero;
        v_flags[c_CF_BIT] = is_wide;
        v_flags[c_OF_BIT] = div_zero;
        v_flags[c_NF_BIT] = is_neg;
        return v_flags;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_div_step
//  Purpose  : One restoring-division iteration: compare the shifted partial
//             remainder with the divisor, subtract when it fits.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider_div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   p,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] partial_next,
    output logic          q_bit
);

    logic [VW-1:0] w_diff;

    // When the subtraction is taken the true result is below the divisor, so
    // the low VW bits of the modular difference are the exact remainder.
    assign q_bit        = (p >= {1'b0, divisor});
    assign w_diff       = p[VW-1:0] - divisor;
    assign partial_next = q_bit ? w_diff : p[VW-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per
//             clock, with start/busy/done handshake and ALU-style flags.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quot,
    output logic [VW-1:0] rem,
    output logic [7:0]    flags
);

    import seq_divider_pkg::*;

    localparam int                c_CW        = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [c_CW-1:0]   c_LAST_ITER = c_CW'(DW - 1);
    localparam logic [DW-1:0]     c_OP_MAX    = DW'((1 << VW) - 1);
    localparam logic [DW-1:0]     c_DBZ_QUOT  = '1;

    state_t          r_state;
    logic [DW-1:0]   r_shift;
    logic [VW-1:0]   r_divisor;
    // The working remainder is VW+1 bits wide only transiently (w_p); what is
    // kept between iterations is always below the divisor and fits VW bits.
    logic [VW-1:0]   r_partial;
    logic [c_CW-1:0] r_count;

    logic [VW:0]     w_p;
    logic [VW-1:0]   w_partial_next;
    logic            w_q_bit;
    logic [DW-1:0]   w_quot_next;
    logic [7:0]      w_flags_next;
    logic [7:0]      w_dbz_flags;

    assign w_p          = {r_partial, r_shift[DW-1]};
    assign w_quot_next  = {r_shift[DW-2:0], w_q_bit};
    assign w_flags_next = make_flags(w_quot_next == '0, w_quot_next[DW-1],
                                     w_quot_next > c_OP_MAX, 1'b0);
    assign w_dbz_flags  = make_flags(c_DBZ_QUOT == '0, c_DBZ_QUOT[DW-1],
                                     c_DBZ_QUOT > c_OP_MAX, 1'b1);

    seq_divider_div_step #(
        .VW (VW)
    ) u_div_step (
        .p            (w_p),
        .divisor      (r_divisor),
        .partial_next (w_partial_next),
        .q_bit        (w_q_bit)
    );

    // Controller, datapath registers and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_divisor <= '0;
            r_partial <= '0;
            r_count   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            flags     <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        r_shift   <= dividend;
                        r_divisor <= divisor;
                        r_partial <= '0;
                        r_count   <= c_LAST_ITER;
                        if (divisor == '0) begin
                            // Divide by zero resolves immediately, no iteration
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            quot    <= c_DBZ_QUOT;
                            rem     <= '0;
                            flags   <= w_dbz_flags;
                        end else begin
                            r_state <= ST_RUN;
                            busy    <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_shift   <= w_quot_next;
                    r_partial <= w_partial_next;
                    r_count   <= r_count - 1'b1;
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        quot    <= w_quot_next;
                        rem     <= w_partial_next;
                        flags   <= w_flags_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider: scoreboard of expected
//             results plus cycle-accurate busy/done timing checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic [7:0] f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quot;
    logic [3:0] rem;
    logic [7:0] flags;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    seq_divider #(
        .DW (8),
        .VW (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Flags {4'b0, NF, OF, CF, ZF}
    function automatic logic [7:0] model_flags(input logic [7:0] q, input logic dz);
        return {4'b0000, q[7], dz, (q > 8'd15), (q == 8'd0)};
    endfunction

    // Drive a start request (called at a falling edge) and record the expected result
    task automatic issue(input logic [7:0] dd, input logic [3:0] dv);
        exp_t e;
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        if (dv == 4'd0) begin
            e.q = 8'hFF;
            e.r = 4'd0;
            e.f = model_flags(8'hFF, 1'b1);
        end else begin
            e.q = dd / {4'b0000, dv};
            e.r = 4'(dd % {4'b0000, dv});
            e.f = model_flags(e.q, 1'b0);
        end
        sb.push_back(e);
    endtask

    // Follow one accepted operation cycle by cycle, checking busy/done timing
    task automatic track(input logic [3:0] dv, input bit glitch, input bit chain,
                         input logic [7:0] dd2, input logic [3:0] dv2);
        int last;
        last = (dv == 4'd0) ? 1 : 9;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (glitch && k == 4) begin
                start    = 1'b1;
                dividend = 8'hAA;
                divisor  = 4'h3;
            end
            check($sformatf("busy_c%0d", k), busy, (k < last) ? 1 : 0);
            check($sformatf("done_c%0d", k), done, (k == last) ? 1 : 0);
            if (chain && k == last)
                issue(dd2, dv2);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    // Scoreboard: compare held results whenever done is seen
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("quot", quot, e.q);
                check("rem", rem, e.r);
                check("flags", flags, e.f);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rdd;
        logic [3:0] rdv;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quot, 0);
        check("rst_rem", rem, 0);
        check("rst_flags", flags, 0);

        // Directed operations
        issue(8'd42, 4'd6);   track(4'd6, 0, 0, 8'd0, 4'd0); idle_cycle();
        issue(8'd200, 4'd7);  track(4'd7, 0, 0, 8'd0, 4'd0); idle_cycle();
        issue(8'd255, 4'd1);  track(4'd1, 0, 0, 8'd0, 4'd0); idle_cycle();
        issue(8'd0, 4'd5);    track(4'd5, 0, 0, 8'd0, 4'd0); idle_cycle();
        issue(8'd9, 4'd0);    track(4'd0, 0, 0, 8'd0, 4'd0); idle_cycle();
        issue(8'd15, 4'd15);  track(4'd15, 0, 0, 8'd0, 4'd0); idle_cycle();

        // Start during RUN is ignored
        issue(8'd42, 4'd6);   track(4'd6, 1, 0, 8'd0, 4'd0); idle_cycle();

        // Back-to-back starts in the DONE cycle, ending with a zero divisor
        issue(8'd100, 4'd9);
        track(4'd9, 0, 1, 8'd77, 4'd5);
        track(4'd5, 0, 1, 8'd13, 4'd0);
        track(4'd0, 0, 0, 8'd0, 4'd0);
        idle_cycle();

        // Random operations
        for (int i = 0; i < 10; i++) begin
            rdd = 8'($urandom_range(0, 255));
            rdv = 4'($urandom_range(0, 15));
            issue(rdd, rdv);
            track(rdv, 0, 0, 8'd0, 4'd0);
            idle_cycle();
        end

        // Known non-zero result, then reset in the middle of the next operation
        issue(8'd200, 4'd7);  track(4'd7, 0, 0, 8'd0, 4'd0); idle_cycle();
        issue(8'd100, 4'd3);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check($sformatf("abort_busy_c%0d", k), busy, 1);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quot", quot, 0);
        check("abort_rem", rem, 0);
        check("abort_flags", flags, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_no_busy", busy, 0);
        end

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
